// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver.
// Synchronises and deglitches the raw PS/2 clock and data lines, deframes
// 11-bit frames (start, 8 data bits LSB-first, odd parity, stop) and reports
// the last good byte together with a count of falling edges since the bus
// last went idle.
//
// Output protocol (no handshake): o_keyValid and o_frameErr are single-cycle
// pulses that are never high together. o_keyData and o_keyDataCnt are levels
// that hold between events, so the consumer may sample them in any cycle.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2Clk,
  input  logic       i_ps2Data,
  output logic [7:0] o_keyData,
  output logic [7:0] o_keyDataCnt,
  output logic       o_keyValid,
  output logic       o_frameErr
);

  localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Index 0 carries the PS/2 clock, index 1 carries the PS/2 data line.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    filt;
  logic [FW-1:0] run [2];
  logic          clk_prev;

  state_t        state, next_state;
  logic [7:0]    shift, next_shift;
  logic [2:0]    idx, next_idx;
  logic          par, next_par;
  logic [TW-1:0] tmo, next_tmo;
  logic [7:0]    next_key;
  logic [7:0]    next_cnt;
  logic          next_valid;
  logic          next_err;

  logic          fall;
  logic          bit_in;
  logic          tmo_hit;

  // Two-flop synchronisers, run-length filters and filtered-clock history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1    <= 2'b11;
      sync2    <= 2'b11;
      filt     <= 2'b11;
      run[0]   <= '0;
      run[1]   <= '0;
      clk_prev <= 1'b1;
    end else begin
      sync1    <= {i_ps2Data, i_ps2Clk};
      sync2    <= sync1;
      clk_prev <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          // Flip only once FILTER_LEN consecutive samples disagree.
          if (run[i] == FW'(FILTER_LEN - 1)) begin
            filt[i] <= sync2[i];
            run[i]  <= '0;
          end else begin
            run[i] <= run[i] + 1'b1;
          end
        end else begin
          run[i] <= '0;
        end
      end
    end
  end

  // The data bit belongs to the same cycle as the filtered clock falling edge.
  assign fall    = clk_prev & ~filt[0];
  assign bit_in  = filt[1];
  // The timeout fires exactly once, on the step into saturation, and an edge
  // in the same cycle takes priority over it.
  assign tmo_hit = ~fall && (tmo == TW'(TIMEOUT_CYCLES - 1));

  // Frame state, shift register, timeout counter and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      shift        <= '0;
      idx          <= '0;
      par          <= 1'b0;
      tmo          <= '0;
      o_keyData    <= '0;
      o_keyDataCnt <= '0;
      o_keyValid   <= 1'b0;
      o_frameErr   <= 1'b0;
    end else begin
      state        <= next_state;
      shift        <= next_shift;
      idx          <= next_idx;
      par          <= next_par;
      tmo          <= next_tmo;
      o_keyData    <= next_key;
      o_keyDataCnt <= next_cnt;
      o_keyValid   <= next_valid;
      o_frameErr   <= next_err;
    end
  end

  // Deframing decisions, edge counting and idle timeout.
  always_comb begin
    next_state = state;
    next_shift = shift;
    next_idx   = idx;
    next_par   = par;
    next_tmo   = tmo;
    next_key   = o_keyData;
    next_cnt   = o_keyDataCnt;
    next_valid = 1'b0;
    next_err   = 1'b0;

    if (fall) begin
      next_tmo = '0;
      if (o_keyDataCnt != 8'hFF) begin
        next_cnt = o_keyDataCnt + 8'd1;
      end
      unique case (state)
        IDLE: begin
          if (!bit_in) begin
            next_state = DATA;
            next_idx   = '0;
          end else begin
            next_err = 1'b1;
          end
        end
        DATA: begin
          next_shift = {bit_in, shift[7:1]};
          next_idx   = idx + 3'd1;
          if (idx == 3'd7) begin
            next_state = PARITY;
          end
        end
        PARITY: begin
          next_par   = bit_in;
          next_state = STOP;
        end
        STOP: begin
          if (bit_in && (^{shift, par})) begin
            next_key   = shift;
            next_valid = 1'b1;
          end else begin
            next_err = 1'b1;
          end
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end else begin
      if (tmo != TW'(TIMEOUT_CYCLES)) begin
        next_tmo = tmo + 1'b1;
      end
      if (tmo_hit) begin
        next_cnt   = '0;
        next_state = IDLE;
        next_err   = (state != IDLE);
      end
    end
  end

endmodule
